// File: rtl/frame_sequencer.sv
// Source-side sequencer for the AC/PH cascade: steps the analog mux round-robin, drops
// settling samples after each switch and forwards whole frames of ADC sample pairs.
module frame_sequencer #(
    parameter int unsigned CHANELS        = 4,
    parameter int unsigned FRAME_LENGTH   = 360,
    parameter int unsigned X_WIDTH        = 16,
    parameter int unsigned SETTLE_SAMPLES = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       adc_vld,
    input  logic [X_WIDTH-1:0]         adc_x1,
    input  logic [X_WIDTH-1:0]         adc_x2,
    output logic [$clog2(CHANELS)-1:0] mux_addr,
    output logic                       o_vld,
    output logic [X_WIDTH-1:0]         x1,
    output logic [X_WIDTH-1:0]         x2,
    output logic [$clog2(CHANELS)-1:0] o_chanel,
    output logic                       o_first,
    output logic                       o_last,
    output logic                       busy
);

    localparam int unsigned AW     = $clog2(CHANELS);
    localparam int unsigned CntMax = (FRAME_LENGTH > SETTLE_SAMPLES) ? FRAME_LENGTH
                                                                     : SETTLE_SAMPLES;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [CW-1:0] FrameLast  = CW'(FRAME_LENGTH - 1);
    localparam logic [CW-1:0] SettleLast = CW'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);
    localparam logic [AW-1:0] ChanLast   = AW'(CHANELS - 1);
    localparam bit            NoSettle   = (SETTLE_SAMPLES == 0);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture} state_e;

    state_e              state_q, state_d;
    state_e              run_state;
    logic   [CW-1:0]     cnt_q, cnt_d;
    logic   [AW-1:0]     chan_q, chan_d;
    logic                fire;

    logic                vld_q;
    logic                first_q;
    logic                last_q;
    logic   [X_WIDTH-1:0] x1_q;
    logic   [X_WIDTH-1:0] x2_q;
    logic   [AW-1:0]     chanel_q;

    // With no settling window a new frame goes straight into capture.
    assign run_state = NoSettle ? StCapture : StSettle;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        fire    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = run_state;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (adc_vld) begin
                    if (cnt_q == SettleLast) begin
                        state_d = StCapture;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StCapture: begin
                if (adc_vld) begin
                    fire = 1'b1;
                    if (cnt_q == FrameLast) begin
                        // Frame end: the channel pointer moves even when stopping, so the
                        // cascade's round-robin address stays aligned across stop/start.
                        cnt_d   = '0;
                        chan_d  = (chan_q == ChanLast) ? '0 : chan_q + 1'b1;
                        state_d = en ? run_state : StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q    <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            x1_q     <= '0;
            x2_q     <= '0;
            chanel_q <= '0;
        end else begin
            vld_q   <= fire;
            first_q <= fire && (cnt_q == '0);
            last_q  <= fire && (cnt_q == FrameLast);
            if (fire) begin
                x1_q     <= adc_x1;
                x2_q     <= adc_x2;
                chanel_q <= chan_q;
            end
        end
    end

    always_comb begin
        mux_addr = chan_q;
        busy     = (state_q != StIdle);
        o_vld    = vld_q;
        o_first  = first_q;
        o_last   = last_q;
        x1       = x1_q;
        x2       = x2_q;
        o_chanel = chanel_q;
    end

    a_first_vld : assert property (@(posedge clk) disable iff (!rstn) o_first |-> o_vld);
    a_last_vld  : assert property (@(posedge clk) disable iff (!rstn) o_last |-> o_vld);
    a_cnt_range : assert property (@(posedge clk) disable iff (!rstn) cnt_q <= FrameLast);

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Source-side sequencer for the AC/PH computing cascade: drives the analog channel multiplexer, discards settling samples after every channel switch, and emits exactly FRAME_LENGTH sample pairs per channel as a valid-qualified stream in strict round-robin channel order. It sits between the dual ADC interface and the cascade input (i_vld/x1/x2). Channel order and frame boundaries must match the cascade's per-frame round-robin address counter.

## Interface
- CHANELS, 4, number of multiplexed channels (≥2)
- FRAME_LENGTH, 360, sample pairs forwarded per channel frame (≥2)
- X_WIDTH, 16, sample width of each ADC lane
- SETTLE_SAMPLES, 8, ADC samples discarded after each mux switch (0 allowed)

- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- en  in  1  run request; level-sensitive
- adc_vld  in  1  one-cycle strobe: new sample pair on adc_x1/adc_x2
- adc_x1  in  X_WIDTH  ADC lane 1 sample
- adc_x2  in  X_WIDTH  ADC lane 2 sample
- mux_addr  out  $clog2(CHANELS)  analog mux select (current channel)
- o_vld  out  1  forwarded sample strobe (cascade i_vld)
- x1  out  X_WIDTH  forwarded lane 1 sample
- x2  out  X_WIDTH  forwarded lane 2 sample
- o_chanel  out  $clog2(CHANELS)  channel of the forwarded sample
- o_first  out  1  high with o_vld on sample 0 of a frame
- o_last  out  1  high with o_vld on sample FRAME_LENGTH-1 of a frame
- busy  out  1  high in SETTLE or CAPTURE

## Operation
- Reset (async, immediate): state IDLE; mux_addr, o_chanel, x1, x2 = 0; o_vld, o_first, o_last, busy = 0; sample counter = 0.
- States: IDLE, SETTLE, CAPTURE.
- IDLE: no output. en=1 → SETTLE (or CAPTURE directly if SETTLE_SAMPLES=0), counter cleared. mux_addr holds the current channel.
- SETTLE: each adc_vld increments counter, sample discarded. On the SETTLE_SAMPLES-th adc_vld → CAPTURE, counter cleared. en is ignored in SETTLE (drop to IDLE only at a frame end).
- CAPTURE: each adc_vld registers adc_x1/adc_x2 to x1/x2, asserts o_vld for one cycle, o_chanel = mux_addr, o_first when counter=0, o_last when counter=FRAME_LENGTH-1; counter increments.
- Frame end (adc_vld with counter=FRAME_LENGTH-1): channel pointer advances (CHANELS-1 wraps to 0), mux_addr updates; next state SETTLE (or CAPTURE if SETTLE_SAMPLES=0) if en=1, else IDLE.
- en deassert mid-frame: frame completes in full; no partial frames ever reach the cascade.
- Channel pointer is never reset by en; only rstn returns it to 0. Keeps downstream round-robin address aligned across stop/start.
- No backpressure: downstream accepts every o_vld. x1/x2 hold last forwarded values when o_vld=0.
- Counter width $clog2(max(FRAME_LENGTH, SETTLE_SAMPLES)+1); no arithmetic on data (pure pass-through, no sign change).

## Timing
- Latency adc_vld → o_vld: 1 cycle, registered outputs.
- mux_addr changes on the clock edge that accepts the last sample of a frame (same edge that raises o_vld/o_last for it); o_chanel of that sample still shows the old channel.
- First discarded settle sample is the first adc_vld strictly after the mux_addr update edge.
- IDLE→SETTLE transition on the first edge with en=1; an adc_vld on that same edge is not counted.
- Back-to-back adc_vld (every cycle) supported at full rate, including across frame boundaries with SETTLE_SAMPLES=0.
- busy falls on the edge entering IDLE.

## Test plan
- CHANELS=3, FRAME_LENGTH=4, SETTLE_SAMPLES=2, en=1, adc_vld every 3rd cycle with incrementing data → per channel: 2 samples dropped, 4 forwarded with o_first on 1st, o_last on 4th; o_chanel sequence 0,1,2,0; mux_addr steps 0→1→2→0 at each o_last edge.
- Same params, SETTLE_SAMPLES=0, adc_vld every cycle → continuous o_vld, no gaps; o_last then o_first on consecutive cycles with channels 0→1.
- en dropped after sample 1 of channel 1 frame → samples 2,3 of channel 1 still forwarded, then IDLE, busy=0; re-assert en → next frame on channel 2 after 2 settle samples.
- rstn asserted mid-CAPTURE (sample 2 of channel 2) → all outputs 0 immediately, no o_last; after release with en=1 → frame restarts on channel 0.
- adc_vld=0 for 50 cycles inside CAPTURE → o_vld stays 0, counter holds, x1/x2 hold; resume continues at next sample index.
- Wrap check: CHANELS=4, run 9 frames → o_chanel frame order 0,1,2,3,0,1,2,3,0; exactly 4 o_vld per frame.
